// File: rtl/synth_pkg.sv
// Shared types and constants for the wavetable voice control path.
// MIDI status nibbles, real-time threshold and FSM state encodings.
package synth_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_PROG     = 4'hC;

  localparam logic [7:0] RT_THRESH   = 8'hF8;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DATA1,
    P_DATA2,
    P_SKIP
  } parse_state_e;

  typedef enum logic [1:0] {
    L_IDLE,
    L_REQ,
    L_WAIT
  } load_state_e;

endpackage

// File: rtl/midi_parser.sv
// MIDI byte parser with running status for one channel.
// Emits a single-cycle msg_dv alongside the byte that completes a message.
module midi_parser
  import synth_pkg::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] midi_byte,
  input  logic       midi_byte_dv,
  output logic       msg_dv,
  output logic [3:0] msg_type,
  output logic [6:0] msg_d1,
  output logic [6:0] msg_d2
);

  parse_state_e state_q, state_d;
  logic [3:0]   rs_q, rs_d;
  logic         rs_vld_q, rs_vld_d;
  logic [6:0]   d1_q, d1_d;
  logic         take_d1;
  logic         chan_ok;

  assign chan_ok = (midi_byte[3:0] == MIDI_CHANNEL) &&
                   ((midi_byte[7:4] == ST_NOTE_OFF) ||
                    (midi_byte[7:4] == ST_NOTE_ON)  ||
                    (midi_byte[7:4] == ST_PROG));

  // Byte decode: status handling, data collection, message completion
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rs_vld_d = rs_vld_q;
    d1_d     = d1_q;
    msg_dv   = 1'b0;
    msg_type = rs_q;
    msg_d1   = midi_byte[6:0];
    msg_d2   = midi_byte[6:0];
    take_d1  = 1'b0;
    if (midi_byte_dv && (midi_byte < RT_THRESH)) begin
      if (midi_byte[7]) begin
        if (chan_ok) begin
          rs_d     = midi_byte[7:4];
          rs_vld_d = 1'b1;
          state_d  = P_DATA1;
        end else begin
          rs_vld_d = 1'b0;
          state_d  = P_SKIP;
        end
      end else begin
        unique case (state_q)
          P_IDLE:  take_d1 = rs_vld_q;
          P_DATA1: take_d1 = 1'b1;
          P_DATA2: begin
            msg_dv  = 1'b1;
            msg_d1  = d1_q;
            state_d = P_IDLE;
          end
          P_SKIP:  ;
        endcase
        if (take_d1) begin
          d1_d = midi_byte[6:0];
          if (rs_q == ST_PROG) begin
            msg_dv  = 1'b1;
            msg_d2  = 7'd0;
            state_d = P_IDLE;
          end else begin
            state_d = P_DATA2;
          end
        end
      end
    end
  end

  // Parser state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= P_IDLE;
      rs_q     <= 4'd0;
      rs_vld_q <= 1'b0;
      d1_q     <= 7'd0;
    end else begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      rs_vld_q <= rs_vld_d;
      d1_q     <= d1_d;
    end
  end

endmodule

// File: rtl/midi_voice_ctrl.sv
// Mono voice control: note registers plus wavetable load sequencing.
// A program is published only once its wavetable load has completed.
module midi_voice_ctrl
  import synth_pkg::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int         NUM_WTB      = 32,
  parameter int         BOOT_LOAD    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] midi_byte,
  input  logic       midi_byte_dv,
  output logic       wtb_load,
  output logic [4:0] wtb_num,
  input  logic [4:0] wtb_load_num,
  input  logic       wtb_load_done,
  output logic [6:0] program_num,
  output logic [6:0] note_num,
  output logic [6:0] note_vel,
  output logic       load_busy
);

  logic       msg_dv;
  logic [3:0] msg_type;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;

  midi_parser #(
    .MIDI_CHANNEL(MIDI_CHANNEL)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .midi_byte   (midi_byte),
    .midi_byte_dv(midi_byte_dv),
    .msg_dv      (msg_dv),
    .msg_type    (msg_type),
    .msg_d1      (msg_d1),
    .msg_d2      (msg_d2)
  );

  load_state_e lstate_q, lstate_d;
  logic [4:0]  wtb_num_q, wtb_num_d;
  logic        wtb_load_q, wtb_load_d;
  logic        busy_q, busy_d;
  logic [6:0]  program_q, program_d;
  logic        pend_vld_q, pend_vld_d;
  logic [4:0]  pend_num_q, pend_num_d;
  logic        boot_done_q;
  logic [6:0]  note_num_q, note_num_d;
  logic [6:0]  note_vel_q, note_vel_d;

  logic pc_req;
  logic note_on;
  logic note_off;
  logic boot_req;
  logic done_hit;

  assign pc_req   = msg_dv && (msg_type == ST_PROG) &&
                    ({25'd0, msg_d1} < 32'(NUM_WTB));
  assign note_on  = msg_dv && (msg_type == ST_NOTE_ON) &&
                    (msg_d2 != 7'd0);
  assign note_off = msg_dv &&
                    ((msg_type == ST_NOTE_OFF) ||
                     ((msg_type == ST_NOTE_ON) && (msg_d2 == 7'd0)));
  assign boot_req = (BOOT_LOAD != 0) && !boot_done_q;
  assign done_hit = wtb_load_done && (wtb_load_num == wtb_num_q);

  // Voice registers: last-note priority, release only the sounding note
  always_comb begin
    note_num_d = note_num_q;
    note_vel_d = note_vel_q;
    if (note_on) begin
      note_num_d = msg_d1;
      note_vel_d = msg_d2;
    end else if (note_off && (msg_d1 == note_num_q)) begin
      note_vel_d = 7'd0;
    end
  end

  // Load sequencer; a same-cycle program change overrides the pending slot
  always_comb begin
    lstate_d   = lstate_q;
    wtb_num_d  = wtb_num_q;
    wtb_load_d = 1'b0;
    busy_d     = busy_q;
    program_d  = program_q;
    pend_vld_d = pend_vld_q;
    pend_num_d = pend_num_q;
    unique case (lstate_q)
      L_IDLE: begin
        if (boot_req || pc_req) begin
          wtb_num_d  = boot_req ? 5'd0 : msg_d1[4:0];
          wtb_load_d = 1'b1;
          busy_d     = 1'b1;
          lstate_d   = L_REQ;
          if (boot_req && pc_req) begin
            pend_vld_d = 1'b1;
            pend_num_d = msg_d1[4:0];
          end
        end
      end
      L_REQ: begin
        lstate_d = L_WAIT;
        if (pc_req) begin
          pend_vld_d = 1'b1;
          pend_num_d = msg_d1[4:0];
        end
      end
      L_WAIT: begin
        if (done_hit) begin
          program_d = {2'b00, wtb_num_q};
          busy_d    = 1'b0;
          lstate_d  = L_IDLE;
          if (pc_req || pend_vld_q) begin
            wtb_num_d  = pc_req ? msg_d1[4:0] : pend_num_q;
            wtb_load_d = 1'b1;
            busy_d     = 1'b1;
            pend_vld_d = 1'b0;
            lstate_d   = L_REQ;
          end
        end else if (pc_req) begin
          pend_vld_d = 1'b1;
          pend_num_d = msg_d1[4:0];
        end
      end
      default: lstate_d = L_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lstate_q    <= L_IDLE;
      wtb_num_q   <= 5'd0;
      wtb_load_q  <= 1'b0;
      busy_q      <= 1'b0;
      program_q   <= 7'd0;
      pend_vld_q  <= 1'b0;
      pend_num_q  <= 5'd0;
      boot_done_q <= 1'b0;
      note_num_q  <= 7'd0;
      note_vel_q  <= 7'd0;
    end else begin
      lstate_q    <= lstate_d;
      wtb_num_q   <= wtb_num_d;
      wtb_load_q  <= wtb_load_d;
      busy_q      <= busy_d;
      program_q   <= program_d;
      pend_vld_q  <= pend_vld_d;
      pend_num_q  <= pend_num_d;
      boot_done_q <= 1'b1;
      note_num_q  <= note_num_d;
      note_vel_q  <= note_vel_d;
    end
  end

  assign wtb_load    = wtb_load_q;
  assign wtb_num     = wtb_num_q;
  assign load_busy   = busy_q;
  assign program_num = program_q;
  assign note_num    = note_num_q;
  assign note_vel    = note_vel_q;

endmodule
